trc_ctrl: RTL and testbench
===========================

# trc_ctrl

Moore-type run/door sequencer for the tram controller. Drives traction enable and door open/close commands from station, door-sensor and operator inputs, and emits the 4-bit status code consumed by the 7-segment status driver. It sits between the operator/sensor inputs and both the actuators and the status display.

## Interface
- DOOR_TIMEOUT, 16: cycles allowed for a door open/close attempt before it counts as failed.
- DWELL_CYCLES, 64: cycles doors are held open at a station.
- HOLD_CYCLES, 8: cycles spent in CLOSED before departure.
- RETRY_MAX, 2: extra door attempts before an error state. Used only with TRC_RETRY_EN.
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  operator start-of-service, level
- stop  in  1  operator end-of-service request, level, latched internally
- at_station  in  1  station-arrival sensor; rising edge is used
- door_open_sns  in  1  doors fully open
- door_closed_sns  in  1  doors fully closed
- fault  in  1  external fault, level
- ack  in  1  operator acknowledge, level
- status  out  4  display code: 0 GoToWork, 1 StopWork, 2 GoToSt, 3 Wait, 4 DrsIsOpen, 5 DrsCntOpen, 6 DrsIsClose, 7 DrsCntClose, 8 SmthWrong
- motor_en  out  1  traction enable
- door_open_cmd  out  1  door-open actuator
- door_close_cmd  out  1  door-close actuator

All inputs arrive already synchronised to clk.

## Operation
- Each state is listed as: code; asserted outputs; transitions.
- IDLE: code 1; no outputs asserted. start=1 goes to START.
- START: code 0; close_cmd asserted. closed_sns goes to RUN. Timeout goes to ERR_CLOSE.
- RUN: code 2; motor_en asserted. at_station rising edge goes to OPENING.
- OPENING: code 3; open_cmd asserted. open_sns goes to DWELL. Timeout is handled as a retry or goes to ERR_OPEN.
- DWELL: code 4; open_cmd asserted. After DWELL_CYCLES, goes to CLOSING.
- CLOSING: code 3; close_cmd asserted. closed_sns goes to CLOSED. Timeout is handled as a retry or goes to ERR_CLOSE.
- CLOSED: code 6; close_cmd asserted. After HOLD_CYCLES, goes to IDLE if stop_pend=1, otherwise to RUN.
- ERR_OPEN: code 5; no outputs asserted. ack goes to RUN; doors stay shut and the station is skipped.
- ERR_CLOSE: code 7; close_cmd asserted. closed_sns goes to CLOSED. ack is ignored in this state.
- FAULT: code 8; all outputs 0. ack with fault=0 goes to IDLE.
- Priority, highest first:
  - fault=1 in any state goes to FAULT.
  - open_sns and closed_sns both 1 in any state except IDLE goes to FAULT (sensor inconsistency).
  - A sensor completion beats a timeout in the same cycle.
- stop_pend:
  - Set by stop=1 in any state except IDLE.
  - Cleared on entering IDLE.
  - stop in IDLE has no effect.
- at_station edge detector:
  - Registered at_prev, reset value 1, so a level already high at reset is not an edge.
  - Edges outside RUN are ignored.
- Timer:
  - One shared counter, width $clog2 of the largest cycle parameter plus 1.
  - Cleared on every state entry, and on every retry.
  - "Timeout" / "after N cycles" means the exit occurs on the cycle where count == N-1, i.e. N cycles spent in the state.
  - The counter saturates and never wraps.

## Timing
- The state register is the only place state changes. status and the commands are decoded from it.
- A qualifying input sampled at edge k changes the outputs after edge k: one-cycle latency.
- Asynchronous reset forces the following values immediately, with no clock needed:
  - state=IDLE, status=4'd1
  - motor_en=0, door_open_cmd=0, door_close_cmd=0
  - timer=0, retry_cnt=0, stop_pend=0, at_prev=1
- Reset mid-sequence aborts the sequence; all commands drop immediately.
- The retry gap deasserts the active door command for exactly 1 cycle. Status does not change during the gap.

## Configuration
- TRC_RETRY_EN defined:
  - An OPENING/CLOSING timeout with retry_cnt < RETRY_MAX increments retry_cnt, inserts the 1-cycle command gap, restarts the timer and stays in the state.
  - Otherwise the timeout goes to the error state.
  - retry_cnt clears on entering DWELL, CLOSED, RUN or IDLE.
- TRC_RETRY_EN undefined:
  - The first timeout goes to the error state.
  - retry_cnt and RETRY_MAX are absent from the logic.

## Structure
- trc_pkg holds:
  - The state enum.
  - The nine status-code localparams, with values equal to the display driver's codes.
- Sub-module trc_timer: clear, enable, saturating count, and the compare against a limit selected per state.

## Test plan
All runs use DOOR_TIMEOUT=8, DWELL_CYCLES=16, HOLD_CYCLES=4, RETRY_MAX=2.
- Nominal cycle:
  - Stimulus: start; closed_sns 3 cycles later; at_station edge; open_sns after 2 cycles; closed_sns after 2 cycles.
  - Required status sequence: 1→0→2→3→4 (16 cycles)→3→6 (4 cycles)→2.
  - motor_en=0 from OPENING through CLOSED.
- Stop request:
  - Stimulus: stop pulse during RUN, then a nominal station stop.
  - Required: after CLOSED (4 cycles), status=1; motor_en stays 0; stop_pend=0.
- Open retry, TRC_RETRY_EN defined:
  - Stimulus: open_sns never arrives.
  - Required: open_cmd high 8, low 1, high 8, low 1, high 8; then status=5.
  - ack then returns status to 2.
- Open failure, TRC_RETRY_EN undefined:
  - Stimulus: open_sns never arrives.
  - Required: status=5 after 8 cycles.
- Fault and sensor conflict:
  - Stimulus: fault during DWELL.
  - Required: status=8 next cycle and all commands 0. ack while fault=1 is ignored; ack after fault=0 gives status=1.
  - Stimulus: open_sns=closed_sns=1 in RUN.
  - Required: status=8.
- Reset and edge corner cases:
  - Stimulus: rst_n low during CLOSING.
  - Required: commands 0 and status=1 immediately.
  - Stimulus: at_station held high through reset release, then start.
  - Required: no OPENING entry until at_station goes low then high.

Source files
------------

// File: rtl/trc_pkg.sv
// Shared types for the tram run/door sequencer: state encoding and status display codes.
package trc_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StRun,
    StOpening,
    StDwell,
    StClosing,
    StClosed,
    StErrOpen,
    StErrClose,
    StFault
  } trc_state_e;

  localparam logic [3:0] StatusGoToWork    = 4'd0;
  localparam logic [3:0] StatusStopWork    = 4'd1;
  localparam logic [3:0] StatusGoToSt      = 4'd2;
  localparam logic [3:0] StatusWait        = 4'd3;
  localparam logic [3:0] StatusDrsIsOpen   = 4'd4;
  localparam logic [3:0] StatusDrsCntOpen  = 4'd5;
  localparam logic [3:0] StatusDrsIsClose  = 4'd6;
  localparam logic [3:0] StatusDrsCntClose = 4'd7;
  localparam logic [3:0] StatusSmthWrong   = 4'd8;

  function automatic logic [3:0] state_status(input trc_state_e state);
    logic [3:0] code;
    code = StatusStopWork;
    unique case (state)
      StIdle:     code = StatusStopWork;
      StStart:    code = StatusGoToWork;
      StRun:      code = StatusGoToSt;
      StOpening:  code = StatusWait;
      StDwell:    code = StatusDrsIsOpen;
      StClosing:  code = StatusWait;
      StClosed:   code = StatusDrsIsClose;
      StErrOpen:  code = StatusDrsCntOpen;
      StErrClose: code = StatusDrsCntClose;
      StFault:    code = StatusSmthWrong;
      default:    code = StatusStopWork;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/trc_timer.sv
// Shared state timer: saturating up-counter with a per-state terminal-count compare.
module trc_timer
  import trc_pkg::*;
#(
  parameter int unsigned DOOR_TIMEOUT = 16,
  parameter int unsigned DWELL_CYCLES = 64,
  parameter int unsigned HOLD_CYCLES  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  trc_state_e state,
  output logic       done
);

  localparam int unsigned MaxDoorDwell = (DOOR_TIMEOUT > DWELL_CYCLES) ? DOOR_TIMEOUT
                                                                      : DWELL_CYCLES;
  localparam int unsigned MaxCycles    = (MaxDoorDwell > HOLD_CYCLES) ? MaxDoorDwell
                                                                      : HOLD_CYCLES;
  localparam int unsigned Width        = $clog2(MaxCycles) + 1;

  logic [Width-1:0] count_q;
  logic [Width-1:0] limit;
  logic             limit_vld;

  // Terminal count is N-1 so the exit edge lands after exactly N cycles in the state.
  always_comb begin
    limit     = '0;
    limit_vld = 1'b0;
    unique case (state)
      StStart, StOpening, StClosing: begin
        limit     = Width'(DOOR_TIMEOUT - 1);
        limit_vld = 1'b1;
      end
      StDwell: begin
        limit     = Width'(DWELL_CYCLES - 1);
        limit_vld = 1'b1;
      end
      StClosed: begin
        limit     = Width'(HOLD_CYCLES - 1);
        limit_vld = 1'b1;
      end
      default: begin
        limit     = '0;
        limit_vld = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign done = limit_vld && (count_q == limit);

endmodule

// File: rtl/trc_ctrl.sv
// Moore run/door sequencer for the tram: traction, door commands and status display code.
// Optional door retry support is enabled by defining TRC_RETRY_EN.
module trc_ctrl
  import trc_pkg::*;
#(
  parameter int unsigned DOOR_TIMEOUT = 16,
  parameter int unsigned DWELL_CYCLES = 64,
  parameter int unsigned HOLD_CYCLES  = 8
`ifdef TRC_RETRY_EN
  ,
  parameter int unsigned RETRY_MAX    = 2
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       at_station,
  input  logic       door_open_sns,
  input  logic       door_closed_sns,
  input  logic       fault,
  input  logic       ack,
  output logic [3:0] status,
  output logic       motor_en,
  output logic       door_open_cmd,
  output logic       door_close_cmd
);

  trc_state_e state_q, state_d;
  logic       at_prev_q;
  logic       stop_pend_q;
  logic       timer_done;
  logic       retry;
  logic       retry_ok;
  logic       gap;
  logic       at_edge;
  logic       state_change;

  assign at_edge      = at_station & ~at_prev_q;
  assign state_change = (state_d != state_q);

  trc_timer #(
    .DOOR_TIMEOUT(DOOR_TIMEOUT),
    .DWELL_CYCLES(DWELL_CYCLES),
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state_change | retry),
    .enable(~gap),
    .state (state_q),
    .done  (timer_done)
  );

`ifdef TRC_RETRY_EN
  localparam int unsigned RetryW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  logic [RetryW-1:0] retry_cnt_q;
  logic              gap_q;

  assign retry_ok = (32'(retry_cnt_q) < RETRY_MAX);
  assign gap      = gap_q;

  // gap_q drops the door command for the single cycle after a retry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt_q <= '0;
      gap_q       <= 1'b0;
    end else begin
      gap_q <= retry;
      if (state_change && (state_d inside {StDwell, StClosed, StRun, StIdle})) begin
        retry_cnt_q <= '0;
      end else if (retry) begin
        retry_cnt_q <= retry_cnt_q + 1'b1;
      end
    end
  end
`else
  assign retry_ok = 1'b0;
  assign gap      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // at_prev resets high so a level already present at reset is not seen as an arrival.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      at_prev_q   <= 1'b1;
      stop_pend_q <= 1'b0;
    end else begin
      at_prev_q <= at_station;
      if (state_change && (state_d == StIdle)) begin
        stop_pend_q <= 1'b0;
      end else if (stop && (state_q != StIdle)) begin
        stop_pend_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    retry   = 1'b0;
    if (fault) begin
      state_d = StFault;
    end else if ((state_q != StIdle) && door_open_sns && door_closed_sns) begin
      state_d = StFault;
    end else begin
      unique case (state_q)
        StIdle:     if (start) state_d = StStart;
        StStart: begin
          if (door_closed_sns)  state_d = StRun;
          else if (timer_done)  state_d = StErrClose;
        end
        StRun:      if (at_edge) state_d = StOpening;
        StOpening: begin
          if (door_open_sns) begin
            state_d = StDwell;
          end else if (timer_done) begin
            if (retry_ok) retry   = 1'b1;
            else          state_d = StErrOpen;
          end
        end
        StDwell:    if (timer_done) state_d = StClosing;
        StClosing: begin
          if (door_closed_sns) begin
            state_d = StClosed;
          end else if (timer_done) begin
            if (retry_ok) retry   = 1'b1;
            else          state_d = StErrClose;
          end
        end
        StClosed:   if (timer_done) state_d = stop_pend_q ? StIdle : StRun;
        StErrOpen:  if (ack) state_d = StRun;
        StErrClose: if (door_closed_sns) state_d = StClosed;
        StFault:    if (ack) state_d = StIdle;
        default:    state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    status         = state_status(state_q);
    motor_en       = 1'b0;
    door_open_cmd  = 1'b0;
    door_close_cmd = 1'b0;
    unique case (state_q)
      StRun:                                 motor_en       = 1'b1;
      StOpening, StDwell:                    door_open_cmd  = ~gap;
      StStart, StClosing, StClosed, StErrClose: door_close_cmd = ~gap;
      default: begin
        motor_en       = 1'b0;
        door_open_cmd  = 1'b0;
        door_close_cmd = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_trc_ctrl.sv
// Directed bench for trc_ctrl with a cycle-level behavioural model checked every cycle.
module tb_trc_ctrl;

  localparam int TO = 8;
  localparam int DW = 16;
  localparam int HD = 4;
`ifdef TRC_RETRY_EN
  localparam int RMAX = 2;
`else
  localparam int RMAX = 0;
`endif
  localparam int DoorFailLen = TO * (RMAX + 1) + RMAX;

  localparam int MIdle = 0, MStart = 1, MRun = 2, MOpen = 3, MDwell = 4;
  localparam int MClose = 5, MClosed = 6, MErrO = 7, MErrC = 8, MFault = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, at_station = 1'b0;
  logic       door_open_sns = 1'b0, door_closed_sns = 1'b0, fault = 1'b0, ack = 1'b0;
  logic [3:0] status;
  logic       motor_en, door_open_cmd, door_close_cmd;

  int checks = 0;
  int errors = 0;

  int m_ph, m_n, m_tries;
  bit m_gap, m_stop, m_at_prev;

  always #5 clk = ~clk;

  trc_ctrl #(
    .DOOR_TIMEOUT(TO),
    .DWELL_CYCLES(DW),
    .HOLD_CYCLES (HD)
`ifdef TRC_RETRY_EN
    ,
    .RETRY_MAX   (RMAX)
`endif
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .stop           (stop),
    .at_station     (at_station),
    .door_open_sns  (door_open_sns),
    .door_closed_sns(door_closed_sns),
    .fault          (fault),
    .ack            (ack),
    .status         (status),
    .motor_en       (motor_en),
    .door_open_cmd  (door_open_cmd),
    .door_close_cmd (door_close_cmd)
  );

  function automatic int m_limit(input int ph);
    case (ph)
      MStart, MOpen, MClose: return TO;
      MDwell:                return DW;
      MClosed:               return HD;
      default:               return 0;
    endcase
  endfunction

  function automatic logic [6:0] model_out();
    int code[10] = '{1, 0, 2, 3, 4, 3, 6, 5, 7, 8};
    logic [3:0] st;
    logic mot, opn, cls;
    st  = 4'(code[m_ph]);
    mot = (m_ph == MRun);
    opn = (m_ph inside {MOpen, MDwell}) && !m_gap;
    cls = (m_ph inside {MStart, MClose, MClosed, MErrC}) && !m_gap;
    return {st, mot, opn, cls};
  endfunction

  task automatic model_reset();
    m_ph = MIdle; m_n = 0; m_tries = 0; m_gap = 0; m_stop = 0; m_at_prev = 1;
  endtask

  // One clock edge of the sequencer, applied with the inputs the DUT is about to sample.
  task automatic model_step();
    int nxt;
    bit rise, expired, again;
    rise      = at_station && !m_at_prev;
    m_at_prev = at_station;
    expired   = (m_limit(m_ph) != 0) && !m_gap && (m_n + 1 >= m_limit(m_ph));
    again     = 0;
    nxt       = m_ph;
    if (fault) nxt = MFault;
    else if (m_ph != MIdle && door_open_sns && door_closed_sns) nxt = MFault;
    else begin
      case (m_ph)
        MIdle:   if (start) nxt = MStart;
        MStart:  if (door_closed_sns) nxt = MRun; else if (expired) nxt = MErrC;
        MRun:    if (rise) nxt = MOpen;
        MOpen:   if (door_open_sns) nxt = MDwell;
                 else if (expired) begin
                   if (m_tries < RMAX) again = 1; else nxt = MErrO;
                 end
        MDwell:  if (expired) nxt = MClose;
        MClose:  if (door_closed_sns) nxt = MClosed;
                 else if (expired) begin
                   if (m_tries < RMAX) again = 1; else nxt = MErrC;
                 end
        MClosed: if (expired) nxt = m_stop ? MIdle : MRun;
        MErrO:   if (ack) nxt = MRun;
        MErrC:   if (door_closed_sns) nxt = MClosed;
        MFault:  if (ack) nxt = MIdle;
        default: nxt = MIdle;
      endcase
    end
    if (nxt == MIdle && m_ph != MIdle) m_stop = 0;
    else if (stop && m_ph != MIdle) m_stop = 1;
    if (nxt != m_ph) begin
      m_n = 0; m_gap = 0;
      if (nxt inside {MDwell, MClosed, MRun, MIdle}) m_tries = 0;
    end else if (again) begin
      m_n = 0; m_gap = 1; m_tries++;
    end else if (m_gap) m_gap = 0;
    else m_n++;
    m_ph = nxt;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    if (rst_n) model_step(); else model_reset();
    @(posedge clk);
    @(negedge clk);
    check("cycle{status,motor,open,close}",
          {1'b0, status, motor_en, door_open_cmd, door_close_cmd}, {1'b0, model_out()});
  endtask

  task automatic count_while(input logic [3:0] code, output int n);
    n = 0;
    while (status == code && n < 200) begin
      n++;
      tick();
    end
  endtask

  // RUN -> arrival -> doors open after 2 cycles -> dwell -> doors close after 2 cycles -> hold.
  task automatic station(output int dwell_n, output int hold_n);
    at_station = 0; tick();
    at_station = 1; tick();
    check("opening_status", {4'b0, status}, 8'd3);
    check("opening_motor", {7'b0, motor_en}, 8'd0);
    at_station = 0; door_closed_sns = 0; tick(); tick();
    door_open_sns = 1; tick();
    check("dwell_status", {4'b0, status}, 8'd4);
    count_while(4'd4, dwell_n);
    door_open_sns = 0; tick(); tick();
    door_closed_sns = 1; tick();
    check("closed_status", {4'b0, status}, 8'd6);
    count_while(4'd6, hold_n);
  endtask

  initial begin
    int d, h, n, lows;
    model_reset();
    #1;
    check("reset_status", {4'b0, status}, 8'd1);
    check("reset_cmds", {5'b0, motor_en, door_open_cmd, door_close_cmd}, 8'd0);
    @(negedge clk);
    rst_n = 1;

    // Nominal service cycle
    start = 1; tick(); start = 0;
    check("start_status", {4'b0, status}, 8'd0);
    check("start_close_cmd", {7'b0, door_close_cmd}, 8'd1);
    tick(); tick();
    door_closed_sns = 1; tick();
    check("run_status", {4'b0, status}, 8'd2);
    station(d, h);
    check("dwell_len", 8'(d), 8'(DW));
    check("hold_len", 8'(h), 8'(HD));
    check("back_to_run", {4'b0, status}, 8'd2);

    // Stop request latched during RUN
    stop = 1; tick(); stop = 0; tick();
    station(d, h);
    check("stop_idle_status", {4'b0, status}, 8'd1);
    tick(); tick();
    check("stop_idle_motor", {7'b0, motor_en}, 8'd0);
    start = 1; tick(); start = 0; tick();
    check("restart_run", {4'b0, status}, 8'd2);
    station(d, h);
    check("stop_pend_cleared", {4'b0, status}, 8'd2);

    // Doors never open
    at_station = 0; tick();
    at_station = 1; tick();
    at_station = 0; door_closed_sns = 0;
    n = 0; lows = 0;
    while (status == 4'd3 && n < 200) begin
      n++;
      if (!door_open_cmd) lows++;
      tick();
    end
    check("open_fail_len", 8'(n), 8'(DoorFailLen));
    check("open_gap_cycles", 8'(lows), 8'(RMAX));
    check("err_open_status", {4'b0, status}, 8'd5);
    ack = 1; tick(); ack = 0;
    check("err_open_ack_run", {4'b0, status}, 8'd2);

    // Doors never close
    at_station = 1; tick();
    at_station = 0; door_open_sns = 1; tick();
    count_while(4'd4, d);
    door_open_sns = 0;
    count_while(4'd3, n);
    check("close_fail_len", 8'(n), 8'(DoorFailLen));
    check("err_close_status", {4'b0, status}, 8'd7);
    ack = 1; tick(); ack = 0;
    check("err_close_ack_ignored", {4'b0, status}, 8'd7);
    door_closed_sns = 1; tick();
    check("err_close_recover", {4'b0, status}, 8'd6);
    count_while(4'd6, h);
    check("after_err_close_run", {4'b0, status}, 8'd2);

    // Fault during DWELL
    at_station = 1; tick();
    at_station = 0; door_closed_sns = 0; door_open_sns = 1; tick();
    tick(); tick();
    fault = 1; tick();
    check("fault_status", {4'b0, status}, 8'd8);
    check("fault_cmds", {5'b0, motor_en, door_open_cmd, door_close_cmd}, 8'd0);
    ack = 1; tick();
    check("fault_ack_held", {4'b0, status}, 8'd8);
    fault = 0; tick(); ack = 0;
    check("fault_cleared_idle", {4'b0, status}, 8'd1);

    // Sensor conflict in RUN
    door_open_sns = 0; door_closed_sns = 1;
    start = 1; tick(); start = 0; tick();
    check("conflict_pre_run", {4'b0, status}, 8'd2);
    door_open_sns = 1; tick();
    check("conflict_fault", {4'b0, status}, 8'd8);
    door_open_sns = 0; ack = 1; tick(); ack = 0;

    // Reset asserted while CLOSING
    start = 1; tick(); start = 0; tick();
    at_station = 1; tick();
    at_station = 0; door_closed_sns = 0; door_open_sns = 1; tick();
    count_while(4'd4, d);
    door_open_sns = 0; tick();
    check("closing_before_reset", {4'b0, status, 3'b0, door_close_cmd}, 8'h31);
    rst_n = 0;
    model_reset();
    #1;
    check("async_reset_status", {4'b0, status}, 8'd1);
    check("async_reset_cmds", {5'b0, motor_en, door_open_cmd, door_close_cmd}, 8'd0);
    at_station = 1; door_closed_sns = 1;
    tick(); tick();
    rst_n = 1;

    // at_station high across reset release is not an arrival
    start = 1; tick(); start = 0; tick();
    tick(); tick(); tick();
    check("no_edge_after_reset", {4'b0, status}, 8'd2);
    at_station = 0; tick();
    at_station = 1; tick();
    check("edge_after_low", {4'b0, status}, 8'd3);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
